// File: rtl/nn_param_writer.sv
// Parameter-store writer: encodes a stream of signed parameters as sign-magnitude words
// and writes them in W1 -> B1 -> W2 -> B2 order into the four parameter RAMs.
module nn_param_writer #(
    parameter int DATA_W = 32,
    parameter int MAG_W  = 27,
    parameter int W1_N   = 100352,
    parameter int B1_N   = 128,
    parameter int W2_N   = 1280,
    parameter int B2_N   = 10,
    parameter int ADDR_W = 17
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_we,
    output logic [1:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] MAG_MAX = {{(DATA_W-MAG_W){1'b0}}, {MAG_W{1'b1}}};
    localparam logic [ADDR_W-1:0] W1_LAST = ADDR_W'(W1_N - 1);
    localparam logic [ADDR_W-1:0] B1_LAST = ADDR_W'(B1_N - 1);
    localparam logic [ADDR_W-1:0] W2_LAST = ADDR_W'(W2_N - 1);
    localparam logic [ADDR_W-1:0] B2_LAST = ADDR_W'(B2_N - 1);

    state_t              r_state;
    logic [1:0]          r_region;
    logic [ADDR_W-1:0]   r_index;

    logic                w_accept;
    logic [DATA_W-1:0]   w_abs;
    logic                w_sat;
    logic [MAG_W-1:0]    w_mag;
    logic [31:0]         w_wdata;
    logic [ADDR_W-1:0]   w_region_last;
    logic                w_idx_last;

    assign in_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign w_accept = in_valid && in_ready;

    // The most negative input has no positive counterpart; its wrapped "absolute value"
    // still has the top bit set, so it falls into the saturating branch as required.
    assign w_abs = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;
    assign w_sat = (w_abs > MAG_MAX);
    assign w_mag = w_sat ? MAG_MAX[MAG_W-1:0] : w_abs[MAG_W-1:0];

    always_comb begin
        w_wdata             = '0;
        w_wdata[MAG_W]      = in_data[DATA_W-1];
        w_wdata[MAG_W-1:0]  = w_mag;
    end

    always_comb begin
        case (r_region)
            2'd0:    w_region_last = W1_LAST;
            2'd1:    w_region_last = B1_LAST;
            2'd2:    w_region_last = W2_LAST;
            default: w_region_last = B2_LAST;
        endcase
    end

    assign w_idx_last = (r_index == w_region_last);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_region  <= 2'd0;
            r_index   <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_region <= 2'd0;
                        r_index  <= '0;
                        sat_flag <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        mem_we    <= 1'b1;
                        mem_sel   <= r_region;
                        mem_addr  <= r_index;
                        mem_wdata <= w_wdata;
                        if (w_sat) begin
                            sat_flag <= 1'b1;
                        end
                        if (w_idx_last) begin
                            r_index <= '0;
                            if (r_region == 2'd3) begin
                                r_state  <= S_DONE;
                                r_region <= 2'd0;
                                done     <= 1'b1;
                            end else begin
                                r_region <= r_region + 2'd1;
                            end
                        end else begin
                            r_index <= r_index + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
